// File: rtl/led_fader.sv
// led_fader: per-LED PWM brightness that ramps toward the target pattern.
// Single clock domain; prescalers produce clock-enable ticks only.
module led_fader #(
  parameter int PWM_DIV  = 2,
  parameter int FADE_DIV = 48,
  parameter int STEP     = 4
) (
  input  logic       CLK50MHz,
  input  logic       RST_N,
  input  logic [7:0] PATTERN,
  output logic [7:0] LED,
  output logic       FADE_BUSY
);

  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_DIV - 1);
  localparam logic [FW-1:0] FADE_LAST = FW'(FADE_DIV - 1);
  localparam logic [7:0]    STEP8     = 8'(STEP);

  localparam logic [1:0] S_OFF     = 2'd0;
  localparam logic [1:0] S_RISING  = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_FALLING = 2'd3;

  logic [PW-1:0] pwm_pre_q, pwm_pre_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [FW-1:0] fade_pre_q, fade_pre_d;
  logic [7:0]    pat_q;
  logic [7:0]    led_q, led_d;
  logic          busy_q, busy_d;
  logic [7:0]    act_d;

  logic pwm_tick;
  logic period_end;
  logic fade_last;
  logic fade_tick;

  always_comb begin
    pwm_tick   = (pwm_pre_q == PWM_LAST);
    pwm_pre_d  = pwm_tick ? '0 : pwm_pre_q + 1'b1;
    pwm_cnt_d  = pwm_tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    period_end = pwm_tick & (pwm_cnt_q == 8'hFF);
    fade_last  = (fade_pre_q == FADE_LAST);
    fade_tick  = period_end & fade_last;
    fade_pre_d = fade_pre_q;
    if (period_end) begin
      fade_pre_d = fade_last ? '0 : fade_pre_q + 1'b1;
    end
  end

  always_ff @(posedge CLK50MHz) begin
    if (!RST_N) begin
      pwm_pre_q  <= '0;
      pwm_cnt_q  <= '0;
      fade_pre_q <= '0;
      pat_q      <= '0;
    end else begin
      pwm_pre_q  <= pwm_pre_d;
      pwm_cnt_q  <= pwm_cnt_d;
      fade_pre_q <= fade_pre_d;
      pat_q      <= PATTERN;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_led
    logic [7:0] br_q, br_d;
    logic [1:0] st_q, st_d;
    logic [8:0] up_sum;

    // Both directions saturate; 9-bit sum exposes the carry out
    always_comb begin
      up_sum = {1'b0, br_q} + {1'b0, STEP8};
      br_d   = br_q;
      if (fade_tick) begin
        if (pat_q[i]) begin
          br_d = up_sum[8] ? 8'hFF : up_sum[7:0];
        end else begin
          br_d = (br_q < STEP8) ? 8'h00 : br_q - STEP8;
        end
      end
    end

    always_comb begin
      st_d = st_q;
      unique case (st_q)
        S_OFF: begin
          if (pat_q[i]) st_d = S_RISING;
        end
        S_RISING: begin
          if (!pat_q[i])          st_d = S_FALLING;
          else if (br_q == 8'hFF) st_d = S_ON;
        end
        S_ON: begin
          if (!pat_q[i]) st_d = S_FALLING;
        end
        S_FALLING: begin
          if (pat_q[i])           st_d = S_RISING;
          else if (br_q == 8'h00) st_d = S_OFF;
        end
        default: st_d = S_OFF;
      endcase
    end

    always_ff @(posedge CLK50MHz) begin
      if (!RST_N) begin
        br_q <= '0;
        st_q <= S_OFF;
      end else begin
        br_q <= br_d;
        st_q <= st_d;
      end
    end

    // Full scale forces a solid 1 instead of a 255/256 duty
    assign led_d[i] = (br_q == 8'hFF) | (br_q > pwm_cnt_q);
    assign act_d[i] = (st_d == S_RISING) | (st_d == S_FALLING);
  end

  assign busy_d = |act_d;

  always_ff @(posedge CLK50MHz) begin
    if (!RST_N) begin
      led_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      busy_q <= busy_d;
    end
  end

  assign LED       = led_q;
  assign FADE_BUSY = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed checks of PWM duty, ramp saturation and busy.
// Fast parameters: one fade tick every 256 clocks.
module tb_led_fader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pattern;
  logic [7:0] led;
  logic       busy;

  led_fader #(
    .PWM_DIV (1),
    .FADE_DIV(1),
    .STEP    (64)
  ) dut (
    .CLK50MHz (clk),
    .RST_N    (rst_n),
    .PATTERN  (pattern),
    .LED      (led),
    .FADE_BUSY(busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  typedef struct {
    logic [7:0] pat;
    int         idx;
    int         duty;
    logic       busy;
  } vec_t;

  vec_t tv[12];
  int   cnt[8];
  logic busy_first;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic run_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_tick();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((cyc % 256) != 0 && n < 300);
    if (n >= 300) begin
      n_chk++;
      $display("FAIL tick_timeout: got %0d edges, expected < 300", n);
    end
  endtask

  // One full PWM period starting right after a fade tick
  task automatic measure();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) busy_first = busy;
      for (int i = 0; i < 8; i++) cnt[i] += int'(led[i]);
    end
  endtask

  initial begin
    int others;
    int all_ok;

    tv[0]  = '{8'h01, 0, 64,  1'b1};
    tv[1]  = '{8'h01, 0, 128, 1'b1};
    tv[2]  = '{8'h01, 0, 192, 1'b1};
    tv[3]  = '{8'h00, 0, 256, 1'b0};
    tv[4]  = '{8'h00, 0, 191, 1'b1};
    tv[5]  = '{8'h00, 0, 127, 1'b1};
    tv[6]  = '{8'h00, 0, 63,  1'b1};
    tv[7]  = '{8'h80, 0, 0,   1'b0};
    tv[8]  = '{8'h80, 7, 64,  1'b1};
    tv[9]  = '{8'h00, 7, 128, 1'b1};
    tv[10] = '{8'h00, 7, 64,  1'b1};
    tv[11] = '{8'h00, 7, 0,   1'b0};

    rst_n   = 1'b0;
    pattern = 8'hFF;
    run_edges(5);
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);

    rst_n = 1'b1;
    run_edges(1);
    check("rel_led", int'(led), 0);
    check("rel_busy", int'(busy), 0);
    pattern = 8'h00;
    run_edges(9);
    check("idle_busy", int'(busy), 0);

    pattern = 8'h01;
    run_edges(1);
    check("busy_c1", int'(busy), 0);
    run_edges(1);
    check("busy_c2", int'(busy), 1);
    goto_tick();

    for (int k = 0; k < 12; k++) begin
      pattern = tv[k].pat;
      measure();
      others = 0;
      for (int i = 0; i < 8; i++)
        if (i != tv[k].idx) others += cnt[i];
      check($sformatf("vec%0d_duty", k), cnt[tv[k].idx], tv[k].duty);
      check($sformatf("vec%0d_others", k), others, 0);
      check($sformatf("vec%0d_busy", k), int'(busy_first), int'(tv[k].busy));
    end

    run_edges(255);
    pattern = 8'h02;
    run_edges(1);
    measure();
    check("simul_up_old", cnt[1], 0);
    measure();
    check("simul_up_new", cnt[1], 64);
    run_edges(255);
    pattern = 8'h00;
    run_edges(1);
    measure();
    check("simul_dn_old", cnt[1], 192);
    measure();
    check("simul_dn_new", cnt[1], 128);

    pattern = 8'hFF;
    run_edges(512);
    run_edges(10);
    check("midramp_busy", int'(busy), 1);
    rst_n = 1'b0;
    run_edges(1);
    check("midrst_led", int'(led), 0);
    check("midrst_busy", int'(busy), 0);
    rst_n = 1'b1;
    run_edges(1);
    check("post_rst_led", int'(led), 0);
    check("post_rst_busy", int'(busy), 0);
    goto_tick();
    measure();
    all_ok = 1;
    for (int i = 0; i < 8; i++)
      if (cnt[i] != 64) all_ok = 0;
    check("restart_duty0", cnt[0], 64);
    check("restart_all64", all_ok, 1);
    check("restart_busy", int'(busy_first), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
